rst_seq_module: RTL and testbench

- Parametrised multi-channel reset sequencer. It holds all downstream reset channels asserted for a programmable time, then releases them one by one in staged order (channel 0 first).
- Supports a software reset request and per-channel output polarity.
- Sits at the top of each design, between the clock source and the UART/datapath blocks. It supersedes the single-channel power-on reset counter.

---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/rst_sat_cnt.sv | 30 +++
 rtl/rst_seq_module.sv | 107 ++++++++++
 tb/tb_rst_seq_module.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged multi-channel reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CH_NUM_MAX = 16;

  // A zero hold request still keeps the channels asserted for one edge.
  function automatic int eff_hold(input int assert_cycle);
    return (assert_cycle < 1) ? 1 : assert_cycle;
  endfunction

endpackage

// File: rtl/rst_sat_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-match flag,
// shared by the hold and staged-release phases of the sequencer.
module rst_sat_cnt #(
  parameter int P_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [P_CNT_W-1:0] match,
  output logic               hit
);

  logic [P_CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, and the
  // reset is sampled inside the clocked block so it stays synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == match);

endmodule

// File: rtl/rst_seq_module.sv
// Multi-channel reset sequencer: holds every channel asserted, then releases
// them one at a time (channel 0 first) with a fixed gap between releases.
module rst_seq_module
  import rst_seq_pkg::*;
#(
  parameter int                  P_CH_NUM       = 4,
  parameter int                  P_CNT_W        = 16,
  parameter int                  P_ASSERT_CYCLE = 16,
  parameter int                  P_STAGE_GAP    = 8,
  parameter logic [P_CH_NUM-1:0] P_OUT_POL      = {P_CH_NUM{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_soft_rst,
  output logic [P_CH_NUM-1:0] o_rst,
  output logic                o_rst_done,
  output logic                o_busy
);

  localparam int                 HOLD        = eff_hold(P_ASSERT_CYCLE);
  localparam int                 IDX_W       = $clog2(P_CH_NUM + 1);
  localparam logic [P_CNT_W-1:0] HOLD_MATCH  = P_CNT_W'(HOLD - 1);
  localparam logic [P_CNT_W-1:0] GAP_MATCH   = P_CNT_W'((P_STAGE_GAP > 0) ? P_STAGE_GAP - 1 : 0);
  localparam bit                 ALL_AT_ONCE = (P_CH_NUM == 1) || (P_STAGE_GAP == 0);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(P_CH_NUM - 1);

  if ((P_CH_NUM < 1) || (P_CH_NUM > CH_NUM_MAX)) begin : g_bad_ch_num
    $fatal(1, "rst_seq_module: P_CH_NUM must be within 1..16");
  end
  if (((P_ASSERT_CYCLE >> P_CNT_W) != 0) || ((P_STAGE_GAP >> P_CNT_W) != 0)) begin : g_bad_cnt_w
    $fatal(1, "rst_seq_module: P_ASSERT_CYCLE/P_STAGE_GAP do not fit in P_CNT_W bits");
  end

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [P_CH_NUM-1:0]  r_act;
  logic [P_CNT_W-1:0]   cnt_match;
  logic                 cnt_hit;
  logic                 cnt_en;
  logic                 cnt_clr;

  // The counter restarts on every release so each stage measures its own gap.
  assign cnt_match = (state == S_HOLD) ? HOLD_MATCH : GAP_MATCH;
  assign cnt_en    = (state != S_DONE);
  assign cnt_clr   = i_soft_rst || (cnt_hit && (state != S_DONE));

  rst_sat_cnt #(
    .P_CNT_W (P_CNT_W)
  ) u_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .match (cnt_match),
    .hit   (cnt_hit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_soft_rst) begin
      state      <= S_HOLD;
      idx        <= '0;
      r_act      <= '1;
      o_rst_done <= 1'b0;
      o_busy     <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt_hit) begin
            if (ALL_AT_ONCE) begin
              r_act      <= '0;
              state      <= S_DONE;
              o_rst_done <= 1'b1;
              o_busy     <= 1'b0;
            end else begin
              r_act[0] <= 1'b0;
              idx      <= IDX_W'(1);
              state    <= S_REL;
            end
          end
        end
        S_REL: begin
          if (cnt_hit) begin
            for (int k = 0; k < P_CH_NUM; k++) begin
              if (IDX_W'(k) == idx) r_act[k] <= 1'b0;
            end
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state      <= S_DONE;
              o_rst_done <= 1'b1;
              o_busy     <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

  // Fixed per-channel inversion of the registered activity vector.
  assign o_rst = ~(r_act ^ P_OUT_POL);

endmodule

// File: tb/tb_rst_seq_module.sv
// Scoreboard bench: four sequencer variants share clock and reset inputs;
// expected output-change events are queued per instance and popped on change.
module tb_rst_seq_module;

  typedef struct {
    int         at;
    logic [3:0] r;
    logic       dn;
  } ev_t;

  typedef struct {
    int         d;
    int         rel;
    logic [3:0] r;
    logic       dn;
  } tbl_t;

  // Uninterrupted sequence per instance: relative edge, o_rst, o_rst_done.
  tbl_t tbl [10] = '{
    '{0, 16, 4'hE, 1'b0}, '{0, 24, 4'hC, 1'b0}, '{0, 32, 4'h8, 1'b0}, '{0, 40, 4'h0, 1'b1},
    '{1, 16, 4'h4, 1'b0}, '{1, 24, 4'h6, 1'b0}, '{1, 32, 4'h2, 1'b0}, '{1, 40, 4'hA, 1'b1},
    '{2, 16, 4'h0, 1'b1},
    '{3,  1, 4'h0, 1'b1}
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic [3:0] d0_rst, d1_rst, d2_rst;
  logic [0:0] d3_rst;
  logic       d0_done, d1_done, d2_done, d3_done;
  logic       d0_busy, d1_busy, d2_busy, d3_busy;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  ev_t q0[$], q1[$], q2[$], q3[$];

  logic [3:0] prev_r  [4] = '{4'hF, 4'h5, 4'hF, 4'h1};
  logic       prev_dn [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic       prev_bz [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rst_seq_module u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
    .o_rst(d0_rst), .o_rst_done(d0_done), .o_busy(d0_busy)
  );
  rst_seq_module #(.P_OUT_POL(4'b0101)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
    .o_rst(d1_rst), .o_rst_done(d1_done), .o_busy(d1_busy)
  );
  rst_seq_module #(.P_STAGE_GAP(0)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
    .o_rst(d2_rst), .o_rst_done(d2_done), .o_busy(d2_busy)
  );
  rst_seq_module #(.P_CH_NUM(1), .P_ASSERT_CYCLE(0), .P_OUT_POL(1'b1)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
    .o_rst(d3_rst), .o_rst_done(d3_done), .o_busy(d3_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic ev_t qpeek(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      2:       return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    ev_t e;
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  task automatic push(input int d, input int at, input logic [3:0] r, input logic dn);
    ev_t e;
    e.at = at; e.r = r; e.dn = dn;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic push_tbl(input int base, input int lim);
    for (int i = 0; i < 10; i++)
      if (tbl[i].rel < lim) push(tbl[i].d, base + tbl[i].rel, tbl[i].r, tbl[i].dn);
  endtask

  task automatic push_reset(input int at);
    push(0, at, 4'hF, 1'b0);
    push(1, at, 4'h5, 1'b0);
    push(2, at, 4'hF, 1'b0);
    push(3, at, 4'h1, 1'b0);
  endtask

  task automatic mon_one(input int d, input logic [3:0] r, input logic dn, input logic bz);
    ev_t  e;
    logic exp_bz;
    bit   more = 1'b1;
    while (more) begin
      if (qsize(d) == 0) more = 1'b0;
      else begin
        e = qpeek(d);
        if (e.at < cyc) begin
          check($sformatf("dut%0d missed event edge", d), cyc, e.at);
          qpop(d);
        end else more = 1'b0;
      end
    end
    if ((r !== prev_r[d]) || (dn !== prev_dn[d]) || (bz !== prev_bz[d])) begin
      if (qsize(d) == 0) begin
        check($sformatf("dut%0d unexpected change", d), {r, dn, bz}, {prev_r[d], prev_dn[d], prev_bz[d]});
      end else begin
        e = qpeek(d);
        qpop(d);
        exp_bz = !e.dn;
        check($sformatf("dut%0d change edge", d), cyc, e.at);
        check($sformatf("dut%0d o_rst", d), r, e.r);
        check($sformatf("dut%0d o_rst_done", d), dn, e.dn);
        check($sformatf("dut%0d o_busy", d), bz, exp_bz);
      end
    end
    prev_r[d]  = r;
    prev_dn[d] = dn;
    prev_bz[d] = bz;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, d0_rst, d0_done, d0_busy);
      mon_one(1, d1_rst, d1_done, d1_busy);
      mon_one(2, d2_rst, d2_done, d2_busy);
      mon_one(3, {3'b000, d3_rst}, d3_done, d3_busy);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int x, b;
    rst_n = 1'b0;
    soft_rst = 1'b0;
    wait_cyc(5);
    check("reset d0 o_rst", d0_rst, 4'hF);
    check("reset d0 o_rst_done", d0_done, 1'b0);
    check("reset d0 o_busy", d0_busy, 1'b1);
    check("reset d1 o_rst", d1_rst, 4'h5);
    check("reset d2 o_rst", d2_rst, 4'hF);
    check("reset d3 o_rst", d3_rst, 1'b1);
    check("reset d3 o_rst_done", d3_done, 1'b0);
    check("reset d3 o_busy", d3_busy, 1'b1);

    // Clean sequences after a power-on style reset.
    push_tbl(5, 1000);
    mon_en = 1'b1;
    rst_n = 1'b1;
    wait_cyc(5 + 45);

    // Hard reset from the done state, then a one-cycle soft reset at edge 28.
    x = cyc;
    push_reset(x + 1);
    rst_n = 1'b0;
    wait_cyc(x + 2);
    b = x + 2;
    push_tbl(b, 28);
    push_reset(b + 28);
    push_tbl(b + 28, 1000);
    rst_n = 1'b1;
    wait_cyc(b + 27);
    soft_rst = 1'b1;
    wait_cyc(b + 28);
    soft_rst = 1'b0;
    wait_cyc(b + 75);

    // Mid-sequence hard reset together with soft reset for three edges.
    x = cyc;
    push_reset(x + 1);
    rst_n = 1'b0;
    wait_cyc(x + 2);
    b = x + 2;
    push_tbl(b, 20);
    push_reset(b + 20);
    push_tbl(b + 22, 1000);
    rst_n = 1'b1;
    wait_cyc(b + 19);
    rst_n = 1'b0;
    soft_rst = 1'b1;
    wait_cyc(b + 22);
    rst_n = 1'b1;
    soft_rst = 1'b0;
    wait_cyc(b + 22 + 45);

    for (int d = 0; d < 4; d++)
      check($sformatf("dut%0d events left pending", d), qsize(d), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
